// File: rtl/axi_inf_pkg.sv
// Shared AXI infrastructure definitions: burst/response codes and the FSM state
// encoding used by the write/read master cores and the write slave core.
package axi_inf_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_DEFAULT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } axi_state_t;

  // Only FIXED and INCR bursts are serviced; WRAP and the reserved code are not.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_inf_burst_addr_gen.sv
// Burst address generator: loads a start address, advances it once per step
// according to burst type and size, and flags bursts it cannot service.
module axi_inf_burst_addr_gen
  import axi_inf_pkg::*;
#(
  parameter int ASIZE    = 32,
  parameter int MAX_SIZE = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ASIZE-1:0] start_addr,
  input  logic [2:0]       size,
  input  logic [1:0]       burst,
  input  logic             step,
  output logic [ASIZE-1:0] addr,
  output logic             unsupported
);

  logic [2:0] size_reg;
  logic [1:0] burst_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      size_reg    <= '0;
      burst_reg   <= '0;
      unsupported <= 1'b0;
    end else if (load) begin
      addr        <= start_addr;
      size_reg    <= size;
      burst_reg   <= burst;
      unsupported <= !burst_supported(burst) || (size > 3'(MAX_SIZE));
    end else if (step && burst_reg == BURST_INCR) begin
      // Wraps modulo 2^ASIZE; the master keeps bursts inside 4KB pages.
      addr <= addr + (ASIZE'(1) << size_reg);
    end
  end

endmodule

// File: rtl/axi_inf_write_slave_core.sv
// AXI4 write slave: accepts one AW burst at a time, turns each W beat into a
// single-cycle local memory write, and answers with a B response.
module axi_inf_write_slave_core
  import axi_inf_pkg::*;
#(
  parameter int IDSIZE = 3,
  parameter int ASIZE  = 32,
  parameter int LSIZE  = 8,
  parameter int DSIZE  = 256
) (
  input  logic                 axi_aclk,
  input  logic                 axi_resetn,
  input  logic [IDSIZE-1:0]    axi_awid,
  input  logic [ASIZE-1:0]     axi_awaddr,
  input  logic [LSIZE-1:0]     axi_awlen,
  input  logic [2:0]           axi_awsize,
  input  logic [1:0]           axi_awburst,
  input  logic                 axi_awvalid,
  output logic                 axi_awready,
  input  logic [DSIZE-1:0]     axi_wdata,
  input  logic [DSIZE/8-1:0]   axi_wstrb,
  input  logic                 axi_wlast,
  input  logic                 axi_wvalid,
  output logic                 axi_wready,
  output logic [IDSIZE-1:0]    axi_bid,
  output logic [1:0]           axi_bresp,
  output logic                 axi_bvalid,
  input  logic                 axi_bready,
  output logic                 mem_wr_en,
  output logic [ASIZE-1:0]     mem_addr,
  output logic [DSIZE-1:0]     mem_data,
  output logic [DSIZE/8-1:0]   mem_strb,
  input  logic                 mem_ready
);

  localparam int MAX_SIZE = $clog2(DSIZE / 8);

  axi_state_t        state_reg;
  logic [IDSIZE-1:0] id_reg;
  logic [LSIZE-1:0]  len_reg;
  logic [LSIZE:0]    count_reg;
  logic              err_reg;
  logic              awready_reg;
  logic              bvalid_reg;
  logic [IDSIZE-1:0] bid_reg;
  logic [1:0]        bresp_reg;

  logic              aw_fire;
  logic              w_fire;
  logic              count_at_len;
  logic              last_beat;
  logic              beat_err;
  logic              unsupported;
  logic [ASIZE-1:0]  cur_addr;

  assign aw_fire      = axi_awvalid & awready_reg;
  assign axi_wready   = (state_reg == ST_DATA) & mem_ready;
  assign w_fire       = axi_wvalid & axi_wready;
  assign count_at_len = (count_reg == {1'b0, len_reg});
  assign last_beat    = count_at_len | axi_wlast;
  // Early last (wlast before len) or missing last (no wlast at len).
  assign beat_err     = axi_wlast ^ count_at_len;

  axi_inf_burst_addr_gen #(
    .ASIZE    (ASIZE),
    .MAX_SIZE (MAX_SIZE)
  ) u_addr_gen (
    .clk         (axi_aclk),
    .rst_n       (axi_resetn),
    .load        (aw_fire),
    .start_addr  (axi_awaddr),
    .size        (axi_awsize),
    .burst       (axi_awburst),
    .step        (w_fire),
    .addr        (cur_addr),
    .unsupported (unsupported)
  );

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_reg   <= ST_IDLE;
      id_reg      <= '0;
      len_reg     <= '0;
      count_reg   <= '0;
      err_reg     <= 1'b0;
      awready_reg <= 1'b0;
      bvalid_reg  <= 1'b0;
      bid_reg     <= '0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          awready_reg <= 1'b1;
          if (aw_fire) begin
            awready_reg <= 1'b0;
            id_reg      <= axi_awid;
            len_reg     <= axi_awlen;
            count_reg   <= '0;
            err_reg     <= 1'b0;
            state_reg   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_fire) begin
            count_reg <= count_reg + {{LSIZE{1'b0}}, 1'b1};
            if (beat_err) err_reg <= 1'b1;
            if (last_beat) begin
              state_reg  <= ST_RESP;
              bvalid_reg <= 1'b1;
              bid_reg    <= id_reg;
              bresp_reg  <= (err_reg | beat_err | unsupported) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        ST_RESP: begin
          if (axi_bready) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign axi_awready = awready_reg;
  assign axi_bvalid  = bvalid_reg;
  assign axi_bid     = bid_reg;
  assign axi_bresp   = bresp_reg;

  // Unsupported bursts still consume beats but never reach the memory.
  assign mem_wr_en = w_fire & ~unsupported;
  assign mem_addr  = mem_wr_en ? cur_addr  : '0;
  assign mem_data  = mem_wr_en ? axi_wdata : '0;
  assign mem_strb  = mem_wr_en ? axi_wstrb : '0;

endmodule
